// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and types for the MIPS CPU front end.
//               RESET_PC_DEFAULT : default fetch PC after reset
//               INSTR_W          : instruction word width
//               NOP_INSTR        : value presented on instr while empty/reset
//               buf_state_e      : occupancy of the fetch output buffer
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          INSTR_W          = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    // EMPTY: nothing buffered, ONE: out register only, TWO: out + skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

endpackage
`default_nettype wire

// File: rtl/ifetch_skid.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_skid
// Description : Two-entry output buffer (out register + skid register) for the
//               instruction fetch stage, with its occupancy FSM.
//   clk, rst          : clock, synchronous active-high reset
//   push              : a returned BRAM word is presented this cycle
//   push_instr/pc     : the returned word and its byte address
//   pop               : the word in the out register is consumed this cycle
//   flush             : discard all buffered words (after any pop)
//   out_valid/instr/pc: registered head-of-buffer presented downstream
//   skid_valid        : the skid register holds a word
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_skid
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [31:0]        push_pc,
    input  logic               pop,
    input  logic               flush,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    output logic               skid_valid
);

    buf_state_e         r_state;
    buf_state_e         w_state_next;
    logic               w_load_out_push;
    logic               w_load_out_skid;
    logic               w_load_skid;

    logic [INSTR_W-1:0] r_out_instr;
    logic [31:0]        r_out_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [31:0]        r_skid_pc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and data-movement enables. A flush wins over everything:
    // any pop in the same cycle has already been taken downstream, and any
    // returning word belongs to the abandoned path.
    always_comb begin
        w_state_next    = r_state;
        w_load_out_push = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        if (flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (push) begin
                        w_state_next    = ONE;
                        w_load_out_push = 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        w_state_next = TWO;
                        w_load_skid  = 1'b1;
                    end else if (push && pop) begin
                        w_load_out_push = 1'b1;
                    end else if (pop) begin
                        w_state_next = EMPTY;
                    end
                end
                TWO: begin
                    // The issue rule never lets a word return into a full,
                    // stalled buffer, so push implies pop here.
                    if (pop) begin
                        w_load_out_skid = 1'b1;
                        if (push) begin
                            w_load_skid = 1'b1;
                        end else begin
                            w_state_next = ONE;
                        end
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_instr  <= NOP_INSTR;
            r_out_pc     <= RESET_PC;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= RESET_PC;
        end else begin
            if (w_load_out_skid) begin
                r_out_instr <= r_skid_instr;
                r_out_pc    <= r_skid_pc;
            end else if (w_load_out_push) begin
                r_out_instr <= push_instr;
                r_out_pc    <= push_pc;
            end
            if (w_load_skid) begin
                r_skid_instr <= push_instr;
                r_skid_pc    <= push_pc;
            end
        end
    end

    assign out_valid  = (r_state != EMPTY);
    assign skid_valid = (r_state == TWO);
    assign out_instr  = r_out_instr;
    assign out_pc     = r_out_pc;

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction fetch stage. Owns the fetch PC, drives the
//               one-cycle-latency instruction BRAM, and hands words to the
//               decoder over a valid/ready handshake, honouring redirects.
//   clk, rst              : clock, synchronous active-high reset
//   imem_en/imem_addr     : BRAM read request (word address)
//   imem_rdata            : BRAM data, one cycle after imem_en
//   redirect_valid/pc     : taken branch/jump and its byte target
//   instr_valid/ready     : handshake to the decoder
//   instr/instr_pc        : fetched word and its byte address
//   fetch_count           : number of completed handshakes (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [31:0]        instr_pc,
    output logic [31:0]        fetch_count
);

    logic [31:0] r_req_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic [31:0] r_fetch_count;

    logic        w_out_valid;
    logic        w_skid_valid;
    logic        w_pop;
    logic        w_push;
    logic [1:0]  w_occ;
    logic [1:0]  w_occ_after_pop;
    logic        w_issue;
    logic        w_unused;

    // Target alignment bits are deliberately dropped.
    assign w_unused = &{1'b0, redirect_pc[1:0]};

    assign w_pop = w_out_valid && instr_ready;

    // Occupancy counts words buffered plus the one still in the BRAM. Only
    // issue if, after this cycle's pop, there will be room for the new word
    // when it returns; this bounds storage at two entries. pop implies
    // out_valid, so the subtraction cannot underflow.
    assign w_occ           = {1'b0, w_out_valid} + {1'b0, w_skid_valid} + {1'b0, r_inflight};
    assign w_occ_after_pop = w_occ - {1'b0, w_pop};
    assign w_issue         = !rst && !redirect_valid && (w_occ_after_pop < 2'd2);

    assign imem_en   = w_issue;
    assign imem_addr = r_req_pc[IMEM_AW+1:2];

    // Data returning during a redirect belongs to the old path.
    assign w_push = r_inflight && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_pc      <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
            r_fetch_count <= 32'd0;
        end else begin
            if (w_pop) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (redirect_valid) begin
                r_req_pc   <= {redirect_pc[31:2], 2'b00};
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_inflight_pc <= r_req_pc;
                    r_req_pc      <= r_req_pc + 32'd4;
                end
            end
        end
    end

    ifetch_skid #(
        .RESET_PC (RESET_PC)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_instr (imem_rdata),
        .push_pc    (r_inflight_pc),
        .pop        (w_pop),
        .flush      (redirect_valid),
        .out_valid  (w_out_valid),
        .out_instr  (instr),
        .out_pc     (instr_pc),
        .skid_valid (w_skid_valid)
    );

    assign instr_valid = w_out_valid;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Self-checking bench for ifetch_unit. A queue-based model of
//               the fetch stream predicts every output each cycle; directed
//               phases pin startup, stall, redirect, reset and wrap with
//               literal expectations, then a randomized phase follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    localparam int IMEM_AW = 10;

    logic               clk;
    logic               rst;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [31:0]        instr;
    logic [31:0]        instr_pc;
    logic [31:0]        fetch_count;

    ifetch_unit #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (IMEM_AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction BRAM: word n holds 32'h1000_0000 + n, one cycle latency.
    logic [31:0] mem [0:(1<<IMEM_AW)-1];
    initial begin
        for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = 32'h1000_0000 + i;
    end
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: byte addresses of words buffered for the decoder in
    // order, plus the single outstanding BRAM request.
    logic [31:0] mq[$];
    bit          m_inflight;
    logic [31:0] m_inflight_pc;
    logic [31:0] m_req;
    logic [31:0] m_count;
    bit          m_known = 1'b0;

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'h1000_0000 + {22'd0, pc[11:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then
    // advance the model by what happens at the coming rising edge.
    task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit exp_valid;
        bit exp_pop;
        bit exp_en;
        int n;
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        #1;
        exp_valid = (mq.size() > 0);
        exp_pop   = exp_valid && rdy;
        n         = mq.size() + int'(m_inflight) - int'(exp_pop);
        exp_en    = !r && !rv && (n < 2);
        if (m_known) begin
            check("instr_valid", {31'd0, instr_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                check("instr_pc", instr_pc, mq[0]);
                check("instr", instr, word_at(mq[0]));
            end
            check("imem_en", {31'd0, imem_en}, {31'd0, exp_en});
            if (exp_en) check("imem_addr", {22'd0, imem_addr}, {22'd0, m_req[11:2]});
            check("fetch_count", fetch_count, m_count);
        end
        if (r) begin
            mq.delete();
            m_inflight = 1'b0;
            m_req      = 32'h0;
            m_count    = 32'd0;
            m_known    = 1'b1;
        end else if (m_known) begin
            if (exp_pop) m_count = m_count + 32'd1;
            if (rv) begin
                mq.delete();
                m_inflight = 1'b0;
                m_req      = {rpc[31:2], 2'b00};
            end else begin
                if (exp_pop) void'(mq.pop_front());
                if (m_inflight) mq.push_back(m_inflight_pc);
                m_inflight = exp_en;
                if (exp_en) begin
                    m_inflight_pc = m_req;
                    m_req         = m_req + 32'd4;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] cnt_snap;
        bit          rr, rv, rdy;
        logic [31:0] rpc;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;

        // Reset state
        repeat (3) step(1, 0, 32'h0, 1);
        check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_fetch_count", fetch_count, 32'h0);
        check("rst_imem_en", {31'd0, imem_en}, 32'd0);

        // Startup and streaming
        step(0, 0, 32'h0, 1);                                   // cycle 0
        check("start_en", {31'd0, imem_en}, 32'd1);
        check("start_addr", {22'd0, imem_addr}, 32'd0);
        step(0, 0, 32'h0, 1);                                   // cycle 1
        check("start_c1_valid", {31'd0, instr_valid}, 32'd0);
        step(0, 0, 32'h0, 1);                                   // cycle 2
        check("start_c2_valid", {31'd0, instr_valid}, 32'd1);
        check("start_c2_instr", instr, 32'h1000_0000);
        check("start_c2_pc", instr_pc, 32'h0);
        step(0, 0, 32'h0, 1);                                   // cycle 3
        check("stream_c3_pc", instr_pc, 32'h4);
        repeat (6) step(0, 0, 32'h0, 1);                        // cycles 4..9
        step(0, 0, 32'h0, 1);                                   // cycle 10
        check("count_after_8", fetch_count, 32'd8);

        // Stall for 5 cycles mid-stream
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        check("stall_en_low", {31'd0, imem_en}, 32'd0);
        step(0, 0, 32'h0, 0);
        step(0, 0, 32'h0, 0);
        repeat (6) step(0, 0, 32'h0, 1);

        // Redirect to a misaligned target
        step(0, 1, 32'h0000_0043, 1);                           // t
        step(0, 0, 32'h0, 1);                                   // t+1
        check("redir_issue_addr", {22'd0, imem_addr}, 32'h10);
        check("redir_t1_valid", {31'd0, instr_valid}, 32'd0);
        step(0, 0, 32'h0, 1);                                   // t+2
        check("redir_t2_valid", {31'd0, instr_valid}, 32'd0);
        step(0, 0, 32'h0, 1);                                   // t+3
        check("redir_t3_pc", instr_pc, 32'h40);
        check("redir_t3_valid", {31'd0, instr_valid}, 32'd1);
        repeat (3) step(0, 0, 32'h0, 1);

        // Redirect with handshake while full (out + skid)
        step(0, 0, 32'h0, 0);                                   // skid fills
        cnt_snap = m_count;
        step(0, 1, 32'h0000_0200, 1);                           // pop + redirect
        step(0, 0, 32'h0, 1);
        check("full_redir_count", fetch_count, cnt_snap + 32'd1);
        check("full_redir_valid", {31'd0, instr_valid}, 32'd0);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        check("full_redir_pc", instr_pc, 32'h200);
        repeat (3) step(0, 0, 32'h0, 1);

        // Reset mid-stream with a request in flight
        step(1, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        check("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check("midrst_addr", {22'd0, imem_addr}, 32'd0);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        check("midrst_pc", instr_pc, 32'h0);
        check("midrst_count", fetch_count, 32'd0);

        // Wrap at the top of the address space
        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 32'h0, 1);
        check("wrap_addr_top", {22'd0, imem_addr}, 32'h3FF);
        step(0, 0, 32'h0, 1);
        check("wrap_addr_zero", {22'd0, imem_addr}, 32'h0);
        step(0, 0, 32'h0, 1);
        check("wrap_pc_top", instr_pc, 32'hFFFF_FFFC);
        check("wrap_instr_top", instr, 32'h1000_03FF);
        step(0, 0, 32'h0, 1);
        check("wrap_pc_zero", instr_pc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rr  = ($urandom_range(0, 199) == 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            rdy = ($urandom_range(0, 9) < 7);
            step(rr, rv, rpc, rdy);
        end
        repeat (4) step(0, 0, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage for the single-cycle/multicycle MIPS CPU, sitting between the PC logic and the Controller/decode stage. It owns the fetch PC and drives the synchronous instruction BRAM, which has one cycle of read latency. It presents each fetched word with its PC to the decoder through a valid/ready handshake. It absorbs downstream stalls without losing words and applies branch/jump redirects, discarding stale fetches.

## Interface
- `RESET_PC`, default `32'h0000_0000`: fetch PC after reset. Bits [1:0] must be 0.
- `IMEM_AW`, default `10`: instruction BRAM word-address width.
- `clk` in 1: the single clock for the block. Also clocks the BRAM.
- `rst` in 1: synchronous, active-high reset.
- `imem_en` out 1: BRAM read enable. One read request per cycle when high.
- `imem_addr` out `IMEM_AW`: word address, equal to `req_pc[IMEM_AW+1:2]`.
- `imem_rdata` in 32: BRAM data, valid the cycle after the matching `imem_en`.
- `redirect_valid` in 1: branch/jump taken this cycle.
- `redirect_pc` in 32: target byte address. Bits [1:0] are ignored and forced to 0.
- `instr_valid` out 1: `instr`/`instr_pc` hold a fetched word.
- `instr_ready` in 1: decoder accepts the word.
- `instr` out 32: instruction word. Registered.
- `instr_pc` out 32: byte address of `instr`. Registered.
- `fetch_count` out 32: number of accepted handshakes. Wraps at 2^32.

## Operation
- **Internal state**
  - `req_pc`: the next address to request.
  - `inflight`: a request was issued last cycle; `inflight_pc` holds its address.
  - Output register `out` (valid/instr/pc) drives the outputs.
  - 1-entry skid register `skid`.
  - Buffer FSM: EMPTY (no valid entries), ONE (`out` only), TWO (`out` + `skid`).
- **Handshake**
  - A word transfers when `instr_valid && instr_ready` in the same cycle.
  - While `instr_valid=1 && instr_ready=0`, `instr`/`instr_pc` stay stable.
- **Issue rule (combinational)**
  - `imem_en = !rst && !redirect_valid && (occ - pop) < 2`.
  - `occ = out.valid + skid.valid + inflight`.
  - `pop = instr_valid && instr_ready`.
  - Every issue increments `req_pc` by 4. Total storage is therefore never exceeded and no word is ever dropped.
- **Data return**
  - Returned data goes into `out` if `out` is empty or being popped and `skid` is empty; otherwise it goes into `skid`.
  - On a pop with `skid` valid, `skid` moves to `out`.
  - Ordering is strictly preserved.
- **FSM transitions**
  - EMPTY→ONE on data return.
  - ONE→TWO on return without pop.
  - TWO→ONE on pop without return.
  - ONE→EMPTY on pop without return.
  - Pop plus return holds the state.
- **Redirect** (sampled at the clock edge of the cycle where it is high)
  - A handshake in the same cycle still completes and counts.
  - Then `out` and `skid` are invalidated and the in-flight return is discarded.
  - `req_pc` is set to `{redirect_pc[31:2],2'b00}`.
  - FSM returns to EMPTY.
- **Back-to-back redirects:** the last one wins. No fetch is issued while `redirect_valid` is high.
- **`req_pc` wrap:** wraps modulo 2^32. `imem_addr` simply truncates.

## Timing
- **Reset values:** `instr_valid=0`, `instr=32'h0`, `instr_pc=RESET_PC`, `fetch_count=0`, `imem_en=0`, `req_pc=RESET_PC`, `inflight=0`, FSM=EMPTY.
- **Reset mid-operation:** all state is cleared at the edge and in-flight data is ignored.
- **Startup:** with `rst` deasserted at cycle 0, `imem_en=1` with the address for `RESET_PC` in cycle 0. The data is captured at the end of cycle 1, so `instr_valid=1` from cycle 2.
- **Redirect latency:** redirect in cycle t → issue of the target in t+1 → `instr_valid` with `instr_pc=target` in t+3.
- **Throughput:** 1 instruction/cycle with `instr_ready` held high.
- **Recovery after a stall:** none needed. The skid entry lets issue resume the cycle `instr_ready` rises, with no bubble.
- **`fetch_count`:** increments the cycle after each handshake.

## Structure
- **Shared package `cpu_pkg`:**
  - `RESET_PC_DEFAULT`
  - `INSTR_W=32`
  - `NOP_INSTR=32'h0`
  - FSM state enum {EMPTY, ONE, TWO}
- **Sub-module `ifetch_skid`:** the 2-entry out/skid buffer with its FSM, taking inputs push/data/pc/pop/flush. The top level keeps `req_pc`, the issue logic, in-flight tracking and `fetch_count`.

## Test plan
- **Startup/streaming:** BRAM preloaded with word n = `32'h1000_0000+n`, `instr_ready=1` → `instr_valid` rises in cycle 2 with `instr=32'h1000_0000` and `instr_pc=0`, then one word per cycle with pc 4, 8, …; `fetch_count=8` after 8 handshakes.
- **Stall:** `instr_ready` low for 5 cycles in mid-stream → `instr` stays stable throughout, `imem_en` drops once 2 entries are occupied, and on release the words continue with no gap and no duplicate.
- **Redirect:** `redirect_valid=1`, `redirect_pc=32'h0000_0043` in cycle t → next accepted `instr_pc=32'h40` in t+3; no word from the old path appears after t.
- **Redirect plus handshake in the same cycle, with the stage full (TWO):** → the popped word counts (`fetch_count`+1), `skid` and in-flight data are discarded, and the next word is the target.
- **Reset mid-stream with `inflight=1`:** → `instr_valid=0` the cycle after reset, and the first word after release comes from `RESET_PC`.
- **Wrap:** redirect to `32'hFFFF_FFFC` with `IMEM_AW=10` → `imem_addr=10'h3FF`, then `req_pc` wraps to 0 and `imem_addr=0`.
